// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads own the RAM whenever a visible pixel
// is fetched; game-logic writes queue in a small FIFO and drain in every other slot.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FB_W       = 160,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        pixelX,
  input  logic [9:0]        pixelY,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic [3:0]        fifo_level,
  output logic              addr_err
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int FB_WORDS = FB_W * (V_ACTIVE / 4);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wr_ready_q, wr_ready_d;
  logic              addr_err_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        vld_pipe_q, act_pipe_q;
  logic [DATA_W-1:0] pix_q, pix_d;

  logic              active, rd_slot, accept, in_range, push, pop;
  logic [7:0]        yb, xb;
  logic [ADDR_W-1:0] rd_addr;
  wr_req_t           head;

  assign active   = ({22'd0, pixelX} < 32'(H_ACTIVE)) && ({22'd0, pixelY} < 32'(V_ACTIVE));
  assign rd_slot  = pix_en && active;
  assign accept   = wr_valid && wr_ready_q;
  assign in_range = 32'(wr_addr) < 32'(FB_WORDS);
  assign push     = accept && in_range;
  assign pop      = !rd_slot && (level_q != '0);
  assign head     = fifo_q[rptr_q];

  // y*160 + x as shifts: 160 = 128 + 32
  assign yb      = pixelY[9:2];
  assign xb      = pixelX[9:2];
  assign rd_addr = (ADDR_W'(yb) << 7) + (ADDR_W'(yb) << 5) + ADDR_W'(xb);

  assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
  assign wr_ready_d = (level_d != LVL_W'(FIFO_DEPTH));

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (rd_slot) begin
      mem_addr_d = rd_addr;
    end else if (pop) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = head.addr;
      mem_wdata_d = head.data;
    end
  end

  always_comb begin
    pix_d = pix_q;
    if (vld_pipe_q[1]) pix_d = act_pipe_q[1] ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      wr_ready_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vld_pipe_q  <= '0;
      act_pipe_q  <= '0;
      pix_q       <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q     <= level_d;
      wr_ready_q  <= wr_ready_d;
      if (accept && !in_range) addr_err_q <= 1'b1;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      // stage 0 lines up with the address, stage 1 with mem_rdata
      vld_pipe_q  <= {vld_pipe_q[0], pix_en};
      act_pipe_q  <= {act_pipe_q[0], active};
      pix_q       <= pix_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign addr_err   = addr_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_data   = pix_q;
  assign fifo_level = 4'(level_q);

endmodule
